// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: CPU address windows and the VRAM/OAM arbiter state type.
package ppu_pkg;

  localparam logic [15:0] VRAM_BASE     = 16'h8000;
  localparam logic [15:0] VRAM_LAST     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [15:0] OAM_LAST      = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_BASE = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_LAST = 16'hFEFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR,
    BLOCKED
  } arb_state_t;

endpackage

// File: rtl/vram_addr_decode.sv
// Combinational CPU address decode into VRAM / OAM / unusable windows.
module vram_addr_decode
  import ppu_pkg::*;
(
  input  logic [15:0] addr,
  output logic        hit_vram,
  output logic        hit_oam,
  output logic        hit_unusable,
  output logic [12:0] offset
);

  assign hit_vram     = (addr >= VRAM_BASE)     && (addr <= VRAM_LAST);
  assign hit_oam      = (addr >= OAM_BASE)      && (addr <= OAM_LAST);
  assign hit_unusable = (addr >= UNUSABLE_BASE) && (addr <= UNUSABLE_LAST);
  // OAM consumers use only the low byte of this offset.
  assign offset       = addr[12:0];

endmodule

// File: rtl/vram_arbiter.sv
// CPU/PPU arbiter for the VRAM and OAM ports.
// Optional macro VRAM_LOCK_EN: honour PPU mode locks; otherwise the CPU steals the VRAM port.
module vram_arbiter
  import ppu_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS_DATA = 8'hFF
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic [12:0] ppu_mem_addr,
  input  logic        ppu_vram_access,
  input  logic        ppu_oam_access,
  output logic [7:0]  ppu_data,
  output logic        ppu_grant,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_q,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wren,
  input  logic [7:0]  oam_q
);

  arb_state_t state, state_nx;

  logic        hit_vram, hit_oam, hit_unusable;
  logic [12:0] offset;
  logic        req_hit, req_blocked;

  logic        tgt_vram;
  logic        unusable_q;
  logic        wr_q;
  logic [12:0] off_q;
  logic [7:0]  wdata_q;
  logic        cpu_owns;

  vram_addr_decode u_dec (
    .addr         (cpu_addr),
    .hit_vram     (hit_vram),
    .hit_oam      (hit_oam),
    .hit_unusable (hit_unusable),
    .offset       (offset)
  );

  assign req_hit = (cpu_rd | cpu_wr) & (hit_vram | hit_oam | hit_unusable);

`ifdef VRAM_LOCK_EN
  assign req_blocked = hit_unusable | (hit_vram & ppu_vram_access) | (hit_oam & ppu_oam_access);
`else
  logic unused_locks;
  assign unused_locks = ppu_vram_access ^ ppu_oam_access;
  assign req_blocked  = hit_unusable;
`endif

  always_ff @(posedge cpu_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_hit) begin
          if (req_blocked) state_nx = BLOCKED;
          else if (cpu_wr) state_nx = WR;
          else             state_nx = RD_WAIT;
        end
      end
      RD_WAIT: state_nx = RD_DONE;
      RD_DONE: state_nx = IDLE;
      WR:      state_nx = IDLE;
      BLOCKED: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ack is registered so it lands in the IDLE cycle after each terminal state.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      cpu_ack    <= 1'b0;
      cpu_rdata  <= 8'h00;
      tgt_vram   <= 1'b0;
      unusable_q <= 1'b0;
      wr_q       <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
    end else begin
      cpu_ack <= (state == RD_DONE) | (state == WR) | (state == BLOCKED);
      if (state == IDLE && req_hit) begin
        tgt_vram   <= hit_vram;
        unusable_q <= hit_unusable;
        wr_q       <= cpu_wr;
        off_q      <= offset;
        wdata_q    <= cpu_wdata;
      end
      if (state == RD_DONE)
        cpu_rdata <= tgt_vram ? vram_q : oam_q;
      if (state == BLOCKED && !wr_q)
        cpu_rdata <= unusable_q ? 8'h00 : OPEN_BUS_DATA;
    end
  end

  assign cpu_owns   = tgt_vram & ((state == RD_WAIT) | (state == WR));
  assign ppu_grant  = ~cpu_owns;
  assign ppu_data   = vram_q;

  assign vram_addr  = cpu_owns ? off_q : ppu_mem_addr;
  assign vram_wdata = wdata_q;
  assign vram_wren  = (state == WR) & tgt_vram;

  assign oam_addr   = off_q[7:0];
  assign oam_wdata  = wdata_q;
  assign oam_wren   = (state == WR) & ~tgt_vram;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with behavioural VRAM/OAM models; adapts expectations to VRAM_LOCK_EN.
module tb_vram_arbiter;

`ifdef VRAM_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        cpu_clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [12:0] ppu_mem_addr;
  logic        ppu_vram_access, ppu_oam_access;
  logic [7:0]  ppu_data;
  logic        ppu_grant;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_wren;
  logic [7:0]  vram_q;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_wren;
  logic [7:0]  oam_q;

  vram_arbiter #(.OPEN_BUS_DATA(8'hFF)) dut (
    .cpu_clock       (cpu_clock),
    .reset           (reset),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rd          (cpu_rd),
    .cpu_wr          (cpu_wr),
    .cpu_rdata       (cpu_rdata),
    .cpu_ack         (cpu_ack),
    .ppu_mem_addr    (ppu_mem_addr),
    .ppu_vram_access (ppu_vram_access),
    .ppu_oam_access  (ppu_oam_access),
    .ppu_data        (ppu_data),
    .ppu_grant       (ppu_grant),
    .vram_addr       (vram_addr),
    .vram_wdata      (vram_wdata),
    .vram_wren       (vram_wren),
    .vram_q          (vram_q),
    .oam_addr        (oam_addr),
    .oam_wdata       (oam_wdata),
    .oam_wren        (oam_wren),
    .oam_q           (oam_q)
  );

  logic [7:0] vmem [0:8191];
  logic [7:0] omem [0:255];

  always @(posedge cpu_clock) begin
    if (vram_wren) vmem[vram_addr] <= vram_wdata;
    if (oam_wren)  omem[oam_addr]  <= oam_wdata;
    vram_q <= vmem[vram_addr];
    oam_q  <= omem[oam_addr];
  end

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  int         ack_at, acks, vwr_at, owr_n;
  logic [7:0] rv;
  bit         glo, amv;

  // One CPU request, then observe five cycles (k = cycles after the request cycle).
  task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d,
                     input bit lock_mid);
    @(negedge cpu_clock);
    cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
    @(posedge cpu_clock);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    if (lock_mid) ppu_vram_access = 1'b1;
    ack_at = 0; acks = 0; vwr_at = 0; owr_n = 0; rv = 8'h00; glo = 1'b0; amv = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge cpu_clock);
      if (cpu_ack) begin
        if (ack_at == 0) begin
          ack_at = k;
          rv     = cpu_rdata;
        end
        acks++;
      end
      if (vram_wren && vwr_at == 0) vwr_at = k;
      if (oam_wren) owr_n++;
      if (!ppu_grant) glo = 1'b1;
      if (vram_addr != ppu_mem_addr) amv = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vmem[i] = 8'h00;
    for (int i = 0; i < 256; i++)  omem[i] = 8'h00;
    vmem[13'h1800] = 8'hC3;
    omem[0]        = 8'h77;

    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    ppu_vram_access = 1'b0; ppu_oam_access = 1'b0; ppu_mem_addr = 13'h0123;
    repeat (3) @(posedge cpu_clock);
    #1 reset = 1'b0;
    @(negedge cpu_clock);
    chk("rst_ack",   32'(cpu_ack),   32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'h00);
    chk("rst_vwren", 32'(vram_wren), 32'd0);
    chk("rst_owren", 32'(oam_wren),  32'd0);
    chk("rst_grant", 32'(ppu_grant), 32'd1);
    chk("rst_vaddr", 32'(vram_addr), 32'h0123);

    // Unlocked write then read of VRAM
    req(1'b0, 1'b1, 16'h8010, 8'h5A, 1'b0);
    chk("wr_ack_cyc",  32'(ack_at), 32'd2);
    chk("wr_ack_once", 32'(acks),   32'd1);
    chk("wr_wren_cyc", 32'(vwr_at), 32'd1);
    chk("wr_grant_lo", 32'(glo),    32'd1);
    req(1'b1, 1'b0, 16'h8010, 8'h00, 1'b0);
    chk("rd_ack_cyc",  32'(ack_at), 32'd3);
    chk("rd_data",     32'(rv),     32'h5A);
    chk("rd_no_wren",  32'(vwr_at), 32'd0);

    // PPU data forwarding
    ppu_mem_addr = 13'h0010;
    @(negedge cpu_clock);
    @(negedge cpu_clock);
    chk("ppu_data", 32'(ppu_data), 32'h5A);
    ppu_mem_addr = 13'h0155;

    // VRAM locked read
    ppu_vram_access = 1'b1;
    req(1'b1, 1'b0, 16'h9800, 8'h00, 1'b0);
    chk("vlock_ack_cyc", 32'(ack_at), LOCK ? 32'd2 : 32'd3);
    chk("vlock_data",    32'(rv),     LOCK ? 32'hFF : 32'hC3);
    chk("vlock_addr_mv", 32'(amv),    LOCK ? 32'd0 : 32'd1);
    ppu_vram_access = 1'b0;

    // OAM locked write, then unlocked read-back
    ppu_oam_access = 1'b1;
    req(1'b0, 1'b1, 16'hFE00, 8'h12, 1'b0);
    chk("olock_ack_cyc", 32'(ack_at), 32'd2);
    chk("olock_wren",    32'(owr_n),  LOCK ? 32'd0 : 32'd1);
    ppu_oam_access = 1'b0;
    req(1'b1, 1'b0, 16'hFE00, 8'h00, 1'b0);
    chk("oam_rd_ack", 32'(ack_at), 32'd3);
    chk("oam_rd_data", 32'(rv),    LOCK ? 32'h77 : 32'h12);

    // Unusable range and ignored address
    req(1'b1, 1'b0, 16'hFEA5, 8'h00, 1'b0);
    chk("unus_ack_cyc", 32'(ack_at), 32'd2);
    chk("unus_data",    32'(rv),     32'h00);
    req(1'b0, 1'b1, 16'hC000, 8'h99, 1'b0);
    chk("ign_no_ack",   32'(acks),   32'd0);
    chk("ign_no_vwren", 32'(vwr_at), 32'd0);
    chk("ign_no_owren", 32'(owr_n),  32'd0);
    req(1'b1, 1'b0, 16'h8010, 8'h00, 1'b0);
    chk("ign_idle_ack", 32'(ack_at), 32'd3);
    chk("ign_idle_rd",  32'(rv),     32'h5A);

    // rd and wr together behave as a write
    req(1'b1, 1'b1, 16'h8020, 8'h66, 1'b0);
    chk("rdwr_wren_cyc", 32'(vwr_at), 32'd1);
    chk("rdwr_ack_cyc",  32'(ack_at), 32'd2);
    req(1'b1, 1'b0, 16'h8020, 8'h00, 1'b0);
    chk("rdwr_readback", 32'(rv),     32'h66);

    // Lock rising after acceptance does not abort
    req(1'b1, 1'b0, 16'h8010, 8'h00, 1'b1);
    chk("late_lock_ack", 32'(ack_at), 32'd3);
    chk("late_lock_rd",  32'(rv),     32'h5A);
    ppu_vram_access = 1'b0;

    // Reset while in RD_WAIT
    @(negedge cpu_clock);
    cpu_addr = 16'h8010; cpu_rd = 1'b1;
    @(posedge cpu_clock);
    #1;
    cpu_rd = 1'b0; reset = 1'b1;
    @(posedge cpu_clock);
    #1 reset = 1'b0;
    @(negedge cpu_clock);
    chk("mid_rst_ack",   32'(cpu_ack),   32'd0);
    chk("mid_rst_grant", 32'(ppu_grant), 32'd1);
    chk("mid_rst_wren",  32'(vram_wren), 32'd0);
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'h00);
    @(negedge cpu_clock);
    chk("mid_rst_ack2",  32'(cpu_ack),   32'd0);

    // CPU steals the VRAM port when locks are not honoured
    ppu_vram_access = 1'b1;
    req(1'b0, 1'b1, 16'h8000, 8'h33, 1'b0);
    chk("steal_wren_cyc", 32'(vwr_at), LOCK ? 32'd0 : 32'd1);
    chk("steal_grant_lo", 32'(glo),    LOCK ? 32'd0 : 32'd1);
    chk("steal_ack_cyc",  32'(ack_at), 32'd2);
    ppu_vram_access = 1'b0;
    req(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0);
    chk("steal_readback", 32'(rv),     LOCK ? 32'h00 : 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
